// File: rtl/i_decode_pipe_pkg.sv
// Shared constants and types for the decode stage.
//   Opcodes of the scalar RV32I groups and the vector VA/VL/VS groups, the VA funct3
//   sub-decodes, fixed instruction field widths, and the enums the decoder uses to
//   select operand register files and immediate layouts.
package i_decode_pipe_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned OPT_W   = 7;
  localparam int unsigned FUNCT_W = 3;

  localparam logic [OPT_W-1:0] OPCODE_B     = 7'b1100011;
  localparam logic [OPT_W-1:0] OPCODE_L     = 7'b0000011;
  localparam logic [OPT_W-1:0] OPCODE_S     = 7'b0100011;
  localparam logic [OPT_W-1:0] OPCODE_I     = 7'b0010011;
  localparam logic [OPT_W-1:0] OPCODE_R     = 7'b0110011;
  localparam logic [OPT_W-1:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [OPT_W-1:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [OPT_W-1:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [OPT_W-1:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [OPT_W-1:0] OPCODE_VA    = 7'b1010111;
  localparam logic [OPT_W-1:0] OPCODE_VL    = 7'b0000111;
  localparam logic [OPT_W-1:0] OPCODE_VS    = 7'b0100111;

  localparam logic [FUNCT_W-1:0] VA_F3_CFG = 3'b111;
  localparam logic [FUNCT_W-1:0] VA_F3_VV  = 3'b000;
  localparam logic [FUNCT_W-1:0] VA_F3_VX  = 3'b100;
  localparam logic [FUNCT_W-1:0] VA_F3_VI  = 3'b011;

  // Which register file an operand index points into; RegNone forces the index to 0.
  typedef enum logic [1:0] {RegNone, RegScalar, RegVector} reg_sel_e;

  typedef enum logic [2:0] {
    ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ, ImmVi, ImmVcfg
  } imm_fmt_e;

endpackage

// File: rtl/i_decode_pipe_if.sv
// Bundle of the fetch-side and buffer-side signals of the decode stage.
//   master: the environment (fetch + i_buffer + flush source)
//   slave : the decode stage itself
//   Fetch side : flush, if_valid, inst, if_pc -> stage; if_vacant <- stage
//   Buffer side: ib_vacant -> stage; ib_valid, ib_opt, ib_funct, ib_rs1, ib_rs2, ib_rd,
//                ib_imm, ib_pc, ib_illegal <- stage
interface i_decode_pipe_if
  import i_decode_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 6
) ();

  logic               flush;
  logic               if_valid;
  logic [INST_W-1:0]  inst;
  logic [XLEN-1:0]    if_pc;
  logic               if_vacant;
  logic               ib_vacant;
  logic               ib_valid;
  logic [OPT_W-1:0]   ib_opt;
  logic [FUNCT_W-1:0] ib_funct;
  logic [REG_W-1:0]   ib_rs1;
  logic [REG_W-1:0]   ib_rs2;
  logic [REG_W-1:0]   ib_rd;
  logic [XLEN-1:0]    ib_imm;
  logic [XLEN-1:0]    ib_pc;
  logic               ib_illegal;

  modport master (
    output flush, if_valid, inst, if_pc, ib_vacant,
    input  if_vacant, ib_valid, ib_opt, ib_funct, ib_rs1, ib_rs2, ib_rd, ib_imm, ib_pc,
           ib_illegal
  );

  modport slave (
    input  flush, if_valid, inst, if_pc, ib_vacant,
    output if_vacant, ib_valid, ib_opt, ib_funct, ib_rs1, ib_rs2, ib_rd, ib_imm, ib_pc,
           ib_illegal
  );

endinterface

// File: rtl/i_decode_pipe_id_decode_comb.sv
// id_decode_comb: purely combinational instruction decoder.
//   inst_i    : 32-bit instruction word
//   opt_o     : inst[6:0], always passed through
//   funct_o   : inst[14:12], always passed through
//   rs1_o/rs2_o/rd_o : register indices, MSB set for vector registers, 0 when unused
//   imm_o     : immediate sign/zero-extended to XLEN, 0 when unused
//   illegal_o : opcode or VA funct3 not decodable (indices and imm forced to 0)
module id_decode_comb
  import i_decode_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 6
) (
  input  logic [INST_W-1:0]  inst_i,
  output logic [OPT_W-1:0]   opt_o,
  output logic [FUNCT_W-1:0] funct_o,
  output logic [REG_W-1:0]   rs1_o,
  output logic [REG_W-1:0]   rs2_o,
  output logic [REG_W-1:0]   rd_o,
  output logic [XLEN-1:0]    imm_o,
  output logic               illegal_o
);

  reg_sel_e    rs1_sel, rs2_sel, rd_sel;
  imm_fmt_e    imm_fmt;
  logic        rs2_at_rd;  // VS stores take their vector source from the rd field
  logic [31:0] imm32;
  logic [4:0]  rs2_fld;

  function automatic logic [REG_W-1:0] sel_reg(reg_sel_e sel, logic [4:0] fld);
    logic [REG_W-1:0] r;
    r = '0;
    if (sel != RegNone) begin
      r = REG_W'(fld);
      if (sel == RegVector) r[REG_W-1] = 1'b1;
    end
    return r;
  endfunction

  assign opt_o   = inst_i[6:0];
  assign funct_o = inst_i[14:12];

  always_comb begin
    rs1_sel   = RegNone;
    rs2_sel   = RegNone;
    rd_sel    = RegNone;
    imm_fmt   = ImmNone;
    rs2_at_rd = 1'b0;
    illegal_o = 1'b0;
    case (opt_o)
      OPCODE_B: begin
        rs1_sel = RegScalar;
        rs2_sel = RegScalar;
        imm_fmt = ImmB;
      end
      OPCODE_L, OPCODE_I, OPCODE_JALR: begin
        rs1_sel = RegScalar;
        rd_sel  = RegScalar;
        imm_fmt = ImmI;
      end
      OPCODE_S: begin
        rs1_sel = RegScalar;
        rs2_sel = RegScalar;
        imm_fmt = ImmS;
      end
      OPCODE_R: begin
        rs1_sel = RegScalar;
        rs2_sel = RegScalar;
        rd_sel  = RegScalar;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        rd_sel  = RegScalar;
        imm_fmt = ImmU;
      end
      OPCODE_JAL: begin
        rd_sel  = RegScalar;
        imm_fmt = ImmJ;
      end
      OPCODE_VA: begin
        case (funct_o)
          VA_F3_CFG: begin
            rs1_sel = RegScalar;
            rd_sel  = RegScalar;
            imm_fmt = ImmVcfg;
          end
          VA_F3_VV: begin
            rs1_sel = RegVector;
            rs2_sel = RegVector;
            rd_sel  = RegVector;
          end
          VA_F3_VX: begin
            rs1_sel = RegScalar;
            rs2_sel = RegVector;
            rd_sel  = RegVector;
          end
          VA_F3_VI: begin
            rs2_sel = RegVector;
            rd_sel  = RegVector;
            imm_fmt = ImmVi;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OPCODE_VL: begin
        rs1_sel = RegScalar;
        rd_sel  = RegVector;
      end
      OPCODE_VS: begin
        rs1_sel   = RegScalar;
        rs2_sel   = RegVector;
        rs2_at_rd = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_fmt)
      ImmI:    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      ImmS:    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      ImmB:    imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      ImmU:    imm32 = {inst_i[31:12], 12'b0};
      ImmJ:    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      ImmVi:   imm32 = {{27{inst_i[19]}}, inst_i[19:15]};
      ImmVcfg: imm32 = {21'b0, inst_i[30:20]};
      default: imm32 = '0;
    endcase
  end

  assign rs2_fld = rs2_at_rd ? inst_i[11:7] : inst_i[24:20];
  assign rs1_o   = sel_reg(rs1_sel, inst_i[19:15]);
  assign rs2_o   = sel_reg(rs2_sel, rs2_fld);
  assign rd_o    = sel_reg(rd_sel, inst_i[11:7]);
  assign imm_o   = XLEN'($signed(imm32));

endmodule

// File: rtl/i_decode_pipe.sv
// i_decode_pipe: registered decode stage between i_fetch and i_buffer.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_io : slave side of i_decode_pipe_if (fetch handshake in, decoded entry out)
// Each accepted word is decoded on the way in and written to a DEPTH-entry queue; the
// queue head drives ib_*. if_vacant is a flop so fetch never sees a combinational path
// from ib_vacant.
module i_decode_pipe
  import i_decode_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  i_decode_pipe_if.slave bus_io
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [OPT_W-1:0]   opt;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic               illegal;
  } entry_t;

  entry_t             entry_in;
  entry_t             head;
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               if_vacant_q, if_vacant_d;
  logic               valid, push, pop;

  id_decode_comb #(
    .XLEN  (XLEN),
    .REG_W (REG_W)
  ) u_decode (
    .inst_i    (bus_io.inst),
    .opt_o     (entry_in.opt),
    .funct_o   (entry_in.funct),
    .rs1_o     (entry_in.rs1),
    .rs2_o     (entry_in.rs2),
    .rd_o      (entry_in.rd),
    .imm_o     (entry_in.imm),
    .illegal_o (entry_in.illegal)
  );
  assign entry_in.pc = bus_io.if_pc;

  assign valid = (count_q != '0);
  assign push  = bus_io.if_valid & if_vacant_q & ~bus_io.flush;
  assign pop   = valid & bus_io.ib_vacant & ~bus_io.flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus_io.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = entry_in;
        wr_ptr_d        = wr_ptr_q + 1'b1;  // power-of-two depth: natural wrap
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if_vacant_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      if_vacant_q <= 1'b1;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if_vacant_q <= if_vacant_d;
    end
  end

  // Zero the fields whenever the queue is empty so stale entries never show.
  assign head = valid ? mem_q[rd_ptr_q] : '0;

  assign bus_io.if_vacant  = if_vacant_q;
  assign bus_io.ib_valid   = valid;
  assign bus_io.ib_opt     = head.opt;
  assign bus_io.ib_funct   = head.funct;
  assign bus_io.ib_rs1     = head.rs1;
  assign bus_io.ib_rs2     = head.rs2;
  assign bus_io.ib_rd      = head.rd;
  assign bus_io.ib_imm     = head.imm;
  assign bus_io.ib_pc      = head.pc;
  assign bus_io.ib_illegal = head.illegal;

endmodule

// File: tb/tb_i_decode_pipe.sv
module tb_i_decode_pipe;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [6:0]  opt;
    logic [2:0]  funct;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errs   = 0;
  exp_t exp_q[$];
  bit   mv = 1'b1;  // model's view of if_vacant after the latest edge

  i_decode_pipe_if #(.XLEN(32), .REG_W(6)) bus ();

  i_decode_pipe #(
    .XLEN  (32),
    .REG_W (6),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: straight from the instruction-format rules.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] sw;
    int a, b, d;
    sw = w;
    a  = int'(w[19:15]);
    b  = int'(w[24:20]);
    d  = int'(w[11:7]);
    e  = '0;
    e.opt   = w[6:0];
    e.funct = w[14:12];
    e.pc    = pc;
    case (w[6:0])
      7'h63: begin
        e.rs1 = 6'(a); e.rs2 = 6'(b);
        e.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      end
      7'h03, 7'h13, 7'h67: begin
        e.rs1 = 6'(a); e.rd = 6'(d); e.imm = 32'(sw >>> 20);
      end
      7'h23: begin
        e.rs1 = 6'(a); e.rs2 = 6'(b); e.imm = 32'((sw >>> 25) * 32 + d);
      end
      7'h33: begin
        e.rs1 = 6'(a); e.rs2 = 6'(b); e.rd = 6'(d);
      end
      7'h37, 7'h17: begin
        e.rd = 6'(d); e.imm = w & 32'hFFFF_F000;
      end
      7'h6F: begin
        e.rd  = 6'(d);
        e.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      end
      7'h57: begin
        case (w[14:12])
          3'd7: begin e.rs1 = 6'(a); e.rd = 6'(d); e.imm = (w >> 20) & 32'h7FF; end
          3'd0: begin e.rs1 = 6'(32 + a); e.rs2 = 6'(32 + b); e.rd = 6'(32 + d); end
          3'd4: begin e.rs1 = 6'(a); e.rs2 = 6'(32 + b); e.rd = 6'(32 + d); end
          3'd3: begin
            e.rs2 = 6'(32 + b); e.rd = 6'(32 + d);
            e.imm = 32'((a >= 16) ? a - 32 : a);
          end
          default: e.illegal = 1'b1;
        endcase
      end
      7'h07: begin e.rs1 = 6'(a); e.rd = 6'(32 + d); end
      7'h27: begin e.rs1 = 6'(a); e.rs2 = 6'(32 + d); end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  // Push side of the scoreboard: accepted words and queue clears happen on the edge.
  always @(posedge clk) begin
    if (rst || bus.flush) begin
      exp_q.delete();
      mv = 1'b1;
    end else begin
      if (bus.if_valid && mv) exp_q.push_back(ref_decode(bus.inst, bus.if_pc));
      mv = (exp_q.size() < DEPTH);
    end
  end

  // Monitor: compare the presented head, pop when the coming edge consumes it.
  always @(negedge clk) begin
    exp_t e;
    check("if_vacant", 64'(bus.if_vacant), 64'(mv));
    check("ib_valid", 64'(bus.ib_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() == 0) begin
      check("idle_idx", 64'({bus.ib_opt, bus.ib_funct, bus.ib_rs1, bus.ib_rs2, bus.ib_rd,
                             bus.ib_illegal}), 64'd0);
      check("idle_imm_pc", {bus.ib_imm, bus.ib_pc}, 64'd0);
    end else begin
      e = exp_q[0];
      check("opt", 64'(bus.ib_opt), 64'(e.opt));
      check("funct", 64'(bus.ib_funct), 64'(e.funct));
      check("rs1", 64'(bus.ib_rs1), 64'(e.rs1));
      check("rs2", 64'(bus.ib_rs2), 64'(e.rs2));
      check("rd", 64'(bus.ib_rd), 64'(e.rd));
      check("imm", 64'(bus.ib_imm), 64'(e.imm));
      check("pc", 64'(bus.ib_pc), 64'(e.pc));
      check("illegal", 64'(bus.ib_illegal), 64'(e.illegal));
      if (bus.ib_vacant && !bus.flush && !rst) void'(exp_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic ibv, input logic fl);
    @(posedge clk);
    #1;
    bus.if_valid  = v;
    bus.inst      = w;
    bus.if_pc     = pc;
    bus.ib_vacant = ibv;
    bus.flush     = fl;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [13];
    logic [31:0] r;
    ops = '{7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h57,
            7'h07, 7'h27, 7'h7F};
    r = $urandom();
    if ($urandom_range(9) == 0) return r;
    return {r[31:7], ops[$urandom_range(12)]};
  endfunction

  localparam logic [31:0] ADDI   = 32'hFFF0_8293;
  localparam logic [31:0] VADDVV = 32'h0220_81D7;
  localparam logic [31:0] VADDVI = 32'h0228_31D7;
  localparam logic [31:0] VAF3_1 = 32'h0220_91D7;
  localparam logic [31:0] OP7F   = 32'h1234_507F;

  initial begin
    bus.if_valid  = 1'b0;
    bus.inst      = '0;
    bus.if_pc     = '0;
    bus.ib_vacant = 1'b0;
    bus.flush     = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ib_valid", 64'(bus.ib_valid), 64'd0);
    check("rst_if_vacant", 64'(bus.if_vacant), 64'd1);
    check("rst_imm", 64'(bus.ib_imm), 64'd0);
    rst = 1'b0;

    // Back-to-back addi: one word out per cycle, one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ADDI, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      if (i >= 1) begin
        check("stream_valid", 64'(bus.ib_valid), 64'd1);
        check("stream_pc", 64'(bus.ib_pc), 64'(32'h100 + 32'(4 * (i - 1))));
        check("stream_rs1", 64'(bus.ib_rs1), 64'd1);
        check("stream_rd", 64'(bus.ib_rd), 64'd5);
        check("stream_imm", 64'(bus.ib_imm), 64'hFFFF_FFFF);
      end
    end
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Buffer stalled while fetch keeps offering: two accepted, head held.
    for (int i = 0; i < 4; i++) step(1'b1, VADDVV, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("stall_if_vacant", 64'(bus.if_vacant), 64'd0);
    check("stall_valid", 64'(bus.ib_valid), 64'd1);
    check("stall_pc", 64'(bus.ib_pc), 64'h200);
    check("vv_rs1", 64'(bus.ib_rs1), 64'h21);
    check("vv_rs2", 64'(bus.ib_rs2), 64'h22);
    check("vv_rd", 64'(bus.ib_rd), 64'h23);
    check("vv_imm", 64'(bus.ib_imm), 64'h0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    step(1'b1, VADDVI, 32'h300, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("vi_imm", 64'(bus.ib_imm), 64'hFFFF_FFF0);
    check("vi_rs1", 64'(bus.ib_rs1), 64'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    step(1'b1, OP7F, 32'h400, 1'b1, 1'b0);
    step(1'b1, VAF3_1, 32'h404, 1'b1, 1'b0);
    check("ill7f_flag", 64'(bus.ib_illegal), 64'd1);
    check("ill7f_pc", 64'(bus.ib_pc), 64'h400);
    check("ill7f_idx", 64'({bus.ib_rs1, bus.ib_rs2, bus.ib_rd}), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("illva_flag", 64'(bus.ib_illegal), 64'd1);
    check("illva_pc", 64'(bus.ib_pc), 64'h404);
    check("illva_imm", 64'(bus.ib_imm), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with the queue full and fetch still offering.
    for (int i = 0; i < 3; i++) step(1'b1, ADDI, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, ADDI, 32'h50C, 1'b0, 1'b1);
    check("preflush_full", 64'(bus.if_vacant), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flush_valid", 64'(bus.ib_valid), 64'd0);
    check("flush_if_vacant", 64'(bus.if_vacant), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flush_no_word", 64'(bus.ib_valid), 64'd0);

    // Asynchronous reset in the middle of a cycle with two words queued.
    step(1'b1, ADDI, 32'h600, 1'b0, 1'b0);
    step(1'b1, ADDI, 32'h604, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("prerst_valid", 64'(bus.ib_valid), 64'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    mv = 1'b1;
    #1;
    check("arst_valid", 64'(bus.ib_valid), 64'd0);
    check("arst_if_vacant", 64'(bus.if_vacant), 64'd1);
    check("arst_fields", 64'({bus.ib_rd, bus.ib_pc}), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(3) != 0), rand_inst(), $urandom() & 32'hFFFF_FFFC,
           1'($urandom_range(2) != 0), 1'($urandom_range(39) == 0));
    end
    repeat (6) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drain_valid", 64'(bus.ib_valid), 64'd0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
